// File: rtl/abs_diff_eval_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : abs_diff_eval_pkg                                            |
// | Description : Shared types and helpers for the abs-diff error sweep.       |
// |               State encoding, default vector count, exact |x-y| and a      |
// |               width-generic saturating adder.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package abs_diff_eval_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Vector count for the default 2-bit operand configuration.
   localparam int unsigned DEF_IN_W = 2;
   localparam int unsigned NUM_VEC  = 1 << (2 * DEF_IN_W);

   // Exact unsigned absolute difference; callers truncate to their width.
   function automatic logic [31:0] absdiff(input logic [31:0] x, input logic [31:0] y);
      return (x > y) ? (x - y) : (y - x);
   endfunction

   // acc + inc clamped to the all-ones value of a w-bit counter (w <= 64).
   // The 65-bit sum cannot overflow, so the compare against the limit is exact.
   function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                           input logic [63:0] inc,
                                           input int          w);
      logic [64:0] sum;
      logic [64:0] lim;
      sum = {1'b0, acc} + {1'b0, inc};
      lim = (65'd1 << w) - 65'd1;
      return (sum > lim) ? lim[63:0] : sum[63:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/abs_diff_err_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : abs_diff_err_acc                                             |
// | Description : Second pipeline stage of the error sweep. For each valid     |
// |               slot computes d = |exact - approx| and accumulates sample    |
// |               count, error count, error sum (all saturating) and the       |
// |               maximum error seen.                                          |
// | Ports       : clk, rst_n        clock / async active-low reset             |
// |               clr_i             synchronous clear of all metrics           |
// |               v_i               slot valid                                 |
// |               exact_i, approx_i reference and circuit result (OUT_W)       |
// |               err_cnt_o, err_sum_o, sample_cnt_o (SUM_W), err_max_o (OUT_W)|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module abs_diff_err_acc
   import abs_diff_eval_pkg::*;
#(
   parameter int OUT_W = 2,
   parameter int SUM_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             v_i,
   input  logic [OUT_W-1:0] exact_i,
   input  logic [OUT_W-1:0] approx_i,
   output logic [SUM_W-1:0] err_cnt_o,
   output logic [SUM_W-1:0] err_sum_o,
   output logic [OUT_W-1:0] err_max_o,
   output logic [SUM_W-1:0] sample_cnt_o
);

   logic [OUT_W-1:0] w_d;
   logic             w_nz;

   logic [SUM_W-1:0] err_cnt_q,    err_cnt_d;
   logic [SUM_W-1:0] err_sum_q,    err_sum_d;
   logic [OUT_W-1:0] err_max_q,    err_max_d;
   logic [SUM_W-1:0] sample_cnt_q, sample_cnt_d;

   assign w_d  = OUT_W'(absdiff(32'(exact_i), 32'(approx_i)));
   assign w_nz = (w_d != '0);

   always_comb begin
      err_cnt_d    = err_cnt_q;
      err_sum_d    = err_sum_q;
      err_max_d    = err_max_q;
      sample_cnt_d = sample_cnt_q;
      if (clr_i) begin
         err_cnt_d    = '0;
         err_sum_d    = '0;
         err_max_d    = '0;
         sample_cnt_d = '0;
      end else if (v_i) begin
         sample_cnt_d = SUM_W'(sat_add(64'(sample_cnt_q), 64'd1, SUM_W));
         err_cnt_d    = SUM_W'(sat_add(64'(err_cnt_q), 64'(w_nz), SUM_W));
         err_sum_d    = SUM_W'(sat_add(64'(err_sum_q), 64'(w_d), SUM_W));
         if (w_d > err_max_q) begin
            err_max_d = w_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q    <= '0;
         err_sum_q    <= '0;
         err_max_q    <= '0;
         sample_cnt_q <= '0;
      end else begin
         err_cnt_q    <= err_cnt_d;
         err_sum_q    <= err_sum_d;
         err_max_q    <= err_max_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   assign err_cnt_o    = err_cnt_q;
   assign err_sum_o    = err_sum_q;
   assign err_max_o    = err_max_q;
   assign sample_cnt_o = sample_cnt_q;

endmodule
`default_nettype wire

// File: rtl/abs_diff_err_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : abs_diff_err_sweep                                           |
// | Description : Exhaustive stimulus source and error-metric accumulator      |
// |               wrapped around a combinational approximate |a-b| netlist.    |
// |               Sweeps every operand pair, registers the circuit output with |
// |               the exact result (S1) and accumulates error metrics (S2).    |
// | Ports       : clk, rst_n          clock / async active-low reset           |
// |               start_i             begin sweep, clear metrics (IDLE/DONE)   |
// |               hold_i              freeze stimulus, inject bubble           |
// |               abort_i             back to IDLE, metrics kept               |
// |               stim_o              {b, a} to the circuit under evaluation   |
// |               dut_out_i           circuit result                           |
// |               busy_o, done_o      status                                   |
// |               err_cnt_o, err_sum_o, err_max_o, sample_cnt_o  metrics       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module abs_diff_err_sweep
   import abs_diff_eval_pkg::*;
#(
   parameter int IN_W  = 2,
   parameter int OUT_W = 2,
   parameter int SUM_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              hold_i,
   input  logic              abort_i,
   output logic [2*IN_W-1:0] stim_o,
   input  logic [OUT_W-1:0]  dut_out_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [SUM_W-1:0]  err_cnt_o,
   output logic [SUM_W-1:0]  err_sum_o,
   output logic [OUT_W-1:0]  err_max_o,
   output logic [SUM_W-1:0]  sample_cnt_o
);

   localparam int                STIM_W     = 2 * IN_W;
   localparam logic [STIM_W-1:0] c_LAST_VEC = '1;

   state_t            state_q, state_d;
   logic [STIM_W-1:0] stim_q,  stim_d;
   logic              v1_q,    v1_d;
   logic [OUT_W-1:0]  exact1_q;
   logic [OUT_W-1:0]  approx1_q;
   logic              w_clr;

   logic [IN_W-1:0]   w_a;
   logic [IN_W-1:0]   w_b;
   logic [IN_W-1:0]   w_abs_in;
   logic [OUT_W-1:0]  w_exact;

   // ------------------------------------------------------------------------
   // Exact reference for the vector currently on stim_o. The difference is
   // formed at operand width and only then resized to the circuit's width.
   // ------------------------------------------------------------------------
   assign w_a      = stim_q[IN_W-1:0];
   assign w_b      = stim_q[STIM_W-1:IN_W];
   assign w_abs_in = IN_W'(absdiff(32'(w_a), 32'(w_b)));
   assign w_exact  = OUT_W'(w_abs_in);

   // ------------------------------------------------------------------------
   // Control FSM and stimulus counter
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      stim_d  = stim_q;
      w_clr   = 1'b0;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  state_d = SWEEP;
                  stim_d  = '0;
                  w_clr   = 1'b1;
               end
            end
            SWEEP: begin
               if (!hold_i) begin
                  if (stim_q == c_LAST_VEC) begin
                     state_d = DRAIN;
                  end else begin
                     stim_d = stim_q + STIM_W'(1);
                  end
               end
            end
            // One DRAIN cycle retires the final S1 slot, so DONE is entered on
            // the same edge that makes the last metric update visible.
            DRAIN: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // The slot presented now is valid only if it is being issued this cycle;
   // a held cycle re-presents the same vector as a bubble.
   assign v1_d = !abort_i && (state_q == SWEEP) && !hold_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         stim_q    <= '0;
         v1_q      <= 1'b0;
         exact1_q  <= '0;
         approx1_q <= '0;
      end else begin
         state_q   <= state_d;
         stim_q    <= stim_d;
         v1_q      <= v1_d;
         exact1_q  <= w_exact;
         approx1_q <= dut_out_i;
      end
   end

   // ------------------------------------------------------------------------
   // S2: metric accumulation
   // ------------------------------------------------------------------------
   abs_diff_err_acc #(
      .OUT_W (OUT_W),
      .SUM_W (SUM_W)
   ) u_acc (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (w_clr),
      .v_i          (v1_q),
      .exact_i      (exact1_q),
      .approx_i     (approx1_q),
      .err_cnt_o    (err_cnt_o),
      .err_sum_o    (err_sum_o),
      .err_max_o    (err_max_o),
      .sample_cnt_o (sample_cnt_o)
   );

   assign stim_o = stim_q;
   assign busy_o = (state_q == SWEEP) || (state_q == DRAIN);
   assign done_o = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_abs_diff_err_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_abs_diff_err_sweep                                        |
// | Description : Self-checking bench for abs_diff_err_sweep. A random lookup  |
// |               table stands in for the approximate circuit; expected        |
// |               metrics come from a direct enumeration of all operand pairs. |
// |               A second instance with a 3-bit metric width sees a circuit   |
// |               tied to zero and exercises saturation.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_abs_diff_err_sweep;

   localparam int IN_W  = 2;
   localparam int OUT_W = 2;
   localparam int SUM_W = 16;
   localparam int SAT_W = 3;
   localparam int NV    = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic hold  = 1'b0;
   logic abort = 1'b0;

   logic [3:0]  stim;
   logic [1:0]  dut_out;
   logic [1:0]  lut [NV];
   logic        busy, done;
   logic [15:0] err_cnt, err_sum, sample_cnt;
   logic [1:0]  err_max;

   logic [3:0]  s_stim;
   logic        s_busy, s_done;
   logic [2:0]  s_err_cnt, s_err_sum, s_sample_cnt;
   logic [1:0]  s_err_max;
   logic [1:0]  zero_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign dut_out  = lut[stim];
   assign zero_out = 2'b00;

   abs_diff_err_sweep #(.IN_W(IN_W), .OUT_W(OUT_W), .SUM_W(SUM_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .hold_i(hold), .abort_i(abort),
      .stim_o(stim), .dut_out_i(dut_out), .busy_o(busy), .done_o(done),
      .err_cnt_o(err_cnt), .err_sum_o(err_sum), .err_max_o(err_max),
      .sample_cnt_o(sample_cnt)
   );

   abs_diff_err_sweep #(.IN_W(IN_W), .OUT_W(OUT_W), .SUM_W(SAT_W)) u_sat (
      .clk(clk), .rst_n(rst_n), .start_i(start), .hold_i(hold), .abort_i(abort),
      .stim_o(s_stim), .dut_out_i(zero_out), .busy_o(s_busy), .done_o(s_done),
      .err_cnt_o(s_err_cnt), .err_sum_o(s_err_sum), .err_max_o(s_err_max),
      .sample_cnt_o(s_sample_cnt)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: enumerate the first nvec operand pairs (a = v%4, b = v/4),
   // total the errors, then clamp each counter to the metric width.
   task automatic model(input int nvec, input int sw, input bit zero,
                        output int c, output int s, output int m, output int n);
      int a, b, ex, ap, d, lim;
      c = 0; s = 0; m = 0; n = 0;
      for (int v = 0; v < nvec; v++) begin
         a  = v % 4;
         b  = v / 4;
         ex = (a > b) ? a - b : b - a;
         ap = zero ? 0 : int'(lut[v]);
         d  = (ex > ap) ? ex - ap : ap - ex;
         n++;
         if (d != 0) c++;
         s += d;
         if (d > m) m = d;
      end
      lim = (1 << sw) - 1;
      if (c > lim) c = lim;
      if (s > lim) s = lim;
      if (n > lim) n = lim;
   endtask

   task automatic check_metrics(input string tag, input int nvec);
      int c, s, m, n;
      model(nvec, SUM_W, 1'b0, c, s, m, n);
      check({tag, "_err_cnt"}, err_cnt, c);
      check({tag, "_err_sum"}, err_sum, s);
      check({tag, "_err_max"}, err_max, m);
      check({tag, "_samples"}, sample_cnt, n);
      model(nvec, SAT_W, 1'b1, c, s, m, n);
      check({tag, "_sat_err_cnt"}, s_err_cnt, c);
      check({tag, "_sat_err_sum"}, s_err_sum, s);
      check({tag, "_sat_err_max"}, s_err_max, m);
      check({tag, "_sat_samples"}, s_sample_cnt, n);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stim"}, stim, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err_cnt"}, err_cnt, 0);
      check({tag, "_err_sum"}, err_sum, 0);
      check({tag, "_err_max"}, err_max, 0);
      check({tag, "_samples"}, sample_cnt, 0);
      check({tag, "_sat_samples"}, s_sample_cnt, 0);
   endtask

   // Called at a negedge. Pulses start, then optionally holds hold_len cycles
   // when stim reaches hold_at and pulses a (to-be-ignored) start at restart_at.
   // cyc counts rising edges from the start edge to the one that shows done.
   task automatic do_sweep(input int hold_at, input int hold_len, input int restart_at,
                           output int cyc);
      int h;
      bit held;
      bit restarted;
      h = 0; restarted = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 200) begin
         held  = 0;
         hold  = 1'b0;
         start = 1'b0;
         if (hold_at >= 0 && stim == 4'(hold_at) && h < hold_len) begin
            hold = 1'b1; held = 1; h++;
         end
         if (restart_at >= 0 && !restarted && stim == 4'(restart_at)) begin
            start = 1'b1; restarted = 1;
         end
         @(negedge clk);
         cyc++;
         if (held) check("hold_frozen", stim, hold_at);
      end
      hold  = 1'b0;
      start = 1'b0;
      check("done_seen", done, 1);
   endtask

   task automatic wait_stim(input int val);
      int n;
      n = 0;
      while (stim != 4'(val) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_stim", stim, val);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, hat, hlen, rat, a, b;
      for (int v = 0; v < NV; v++) lut[v] = 2'b00;

      // Reset state
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Exact circuit looped back
      for (int v = 0; v < NV; v++) begin
         a = v % 4; b = v / 4;
         lut[v] = 2'((a > b) ? a - b : b - a);
      end
      do_sweep(-1, 0, -1, cyc);
      check("exact_cycles", cyc, 18);
      check("exact_stim_end", stim, 15);
      check("exact_busy", busy, 0);
      check_metrics("exact", NV);

      // Circuit tied to zero
      for (int v = 0; v < NV; v++) lut[v] = 2'b00;
      do_sweep(-1, 0, -1, cyc);
      check("zero_cycles", cyc, 18);
      check("zero_err_cnt_abs", err_cnt, 12);
      check("zero_err_sum_abs", err_sum, 20);
      check("zero_err_max_abs", err_max, 3);
      check_metrics("zero", NV);

      // Hold five cycles at stim = 6
      do_sweep(6, 5, -1, cyc);
      check("hold_cycles", cyc, 23);
      check_metrics("hold", NV);

      // Abort with stim = 8 on the bus: vectors 0..7 are already accumulated
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_stim(8);
      abort = 1'b1; @(negedge clk); abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_samples", sample_cnt, 8);
      check_metrics("abort", 8);
      repeat (3) @(negedge clk);
      check_metrics("abort_held", 8);

      // Restart after abort repeats the full zero sweep
      do_sweep(-1, 0, -1, cyc);
      check("restart_cycles", cyc, 18);
      check_metrics("restart", NV);

      // start together with abort in DONE: abort wins, metrics kept
      start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0;
      check("abort_start_busy", busy, 0);
      check("abort_start_done", done, 0);
      @(negedge clk);
      check("abort_start_busy2", busy, 0);
      check_metrics("abort_start", NV);

      // Asynchronous reset in DRAIN
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_stim(15);
      @(negedge clk);
      check("drain_busy", busy, 1);
      check("drain_done", done, 0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_sweep(-1, 0, -1, cyc);
      check("post_rst_cycles", cyc, 18);
      check_metrics("post_rst", NV);

      // Random circuits, random hold, ignored start mid-sweep
      for (int it = 0; it < 6; it++) begin
         for (int v = 0; v < NV; v++) lut[v] = 2'($urandom_range(0, 3));
         hat  = int'($urandom_range(0, 14));
         hlen = int'($urandom_range(0, 4));
         rat  = int'($urandom_range(1, 14));
         do_sweep(hat, hlen, rat, cyc);
         check("rand_cycles", cyc, 18 + hlen);
         check("rand_stim_end", stim, 15);
         check_metrics("rand", NV);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
